// File: rtl/mbs_pkg.sv
// Types and sizes shared by the multiplier, the BCD converter and the top level.
package mbs_pkg;

    localparam int LARGURA_PRODUTO = 16;
    localparam int DIGITOS_BCD     = 5;

    typedef enum logic [1:0] {
        REPOUSO = 2'b00,
        DESLOCA = 2'b01,
        FIM     = 2'b10
    } estado_t;

endpackage

// File: rtl/ajuste_digito.sv
// Add-3 correction for one BCD digit, applied before each doubling shift.
module ajuste_digito (
    input  logic [3:0] digito,
    output logic [3:0] ajustado
);

    assign ajustado = (digito >= 4'd5) ? digito + 4'd3 : digito;

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Binary to packed BCD converter, one double-dabble iteration per clock.
module conversor_bcd_sequencial
    import mbs_pkg::*;
#(
    parameter int LARGURA = LARGURA_PRODUTO,
    parameter int DIGITOS = DIGITOS_BCD
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LARGURA-1:0]     valor,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   pronto,
    output logic                   ocupado
);

    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    estado_t                 estado;
    estado_t                 estado_prox;
    logic [LARGURA-1:0]      reg_bin;
    logic [4*DIGITOS-1:0]    reg_bcd;
    logic [4*DIGITOS-1:0]    reg_bcd_aj;
    logic [CW-1:0]           contador;
    logic [4*DIGITOS+LARGURA-1:0] deslocado;

    for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
        ajuste_digito u_ajuste (
            .digito   (reg_bcd[4*i +: 4]),
            .ajustado (reg_bcd_aj[4*i +: 4])
        );
    end

    // The bit leaving the top of the scratch is always 0 for valid parameters.
    assign deslocado = {reg_bcd_aj, reg_bin} << 1;

    always_comb begin
        estado_prox = REPOUSO;
        case (estado)
            REPOUSO: estado_prox = start ? DESLOCA : REPOUSO;
            DESLOCA: estado_prox = (contador == ULTIMO) ? FIM : DESLOCA;
            FIM:     estado_prox = REPOUSO;
            default: estado_prox = REPOUSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado <= REPOUSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            reg_bin  <= '0;
            reg_bcd  <= '0;
            contador <= '0;
            bcd      <= '0;
            pronto   <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                REPOUSO: begin
                    if (start) begin
                        reg_bin  <= valor;
                        reg_bcd  <= '0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                    end
                end
                DESLOCA: begin
                    {reg_bcd, reg_bin} <= deslocado;
                    if (contador != ULTIMO) begin
                        contador <= contador + 1'b1;
                    end
                end
                FIM: begin
                    bcd     <= reg_bcd;
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                end
                default: begin
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Directed and random checks of the sequential BCD converter against a decimal model.
module tb_conversor_bcd_sequencial;

    localparam int L = 16;
    localparam int D = 5;
    localparam int LAT = L + 1;

    logic            clock;
    logic            reset_n;
    logic            start;
    logic [L-1:0]    valor;
    logic [4*D-1:0]  bcd;
    logic            pronto;
    logic            ocupado;

    conversor_bcd_sequencial #(.LARGURA(L), .DIGITOS(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .valor   (valor),
        .bcd     (bcd),
        .pronto  (pronto),
        .ocupado (ocupado)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state
    logic [4*D-1:0] exp_q[$];
    int             exp_t_q[$];
    int             total = 0;
    int             bad = 0;
    int             pronto_cnt = 0;
    logic [4*D-1:0] last_bcd = '0;
    int             occ_run = 0;
    logic           prev_occ = 1'b0;
    logic           prev_pronto = 1'b0;

    task automatic check(input string nome, input int atual, input int esperado);
        total++;
        if (atual != esperado) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    function automatic logic [4*D-1:0] golden(input int v);
        logic [4*D-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // monitor
    always @(negedge clock) begin
        if (!reset_n) begin
            last_bcd    = '0;
            occ_run     = 0;
            prev_occ    = 1'b0;
            prev_pronto = 1'b0;
        end else begin
            if (pronto) begin
                pronto_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pronto", 1, 0);
                end else begin
                    check("bcd_result", int'(bcd), int'(exp_q.pop_front()));
                    check("pronto_cycle", cyc, exp_t_q.pop_front());
                end
                check("pronto_one_cycle", int'(prev_pronto), 0);
                last_bcd = bcd;
            end else begin
                check("bcd_stable", int'(bcd), int'(last_bcd));
            end
            if (ocupado) begin
                occ_run++;
            end else if (prev_occ) begin
                check("ocupado_len", occ_run, LAT);
                occ_run = 0;
            end
            prev_occ    = ocupado;
            prev_pronto = pronto;
        end
    end

    // driver tasks, called at a falling edge
    task automatic issue(input logic [L-1:0] v, input logic [4*D-1:0] e);
        start = 1'b1;
        valor = v;
        @(negedge clock);
        exp_q.push_back(e);
        exp_t_q.push_back(cyc + LAT);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_idle", 1, 0);
            exp_q.delete();
            exp_t_q.delete();
        end
    endtask

    initial begin
        int p0;
        int n;
        logic [L-1:0] v;

        reset_n = 1'b0;
        start   = 1'b0;
        valor   = '0;
        repeat (3) @(negedge clock);
        check("reset_bcd", int'(bcd), 0);
        check("reset_pronto", int'(pronto), 0);
        check("reset_ocupado", int'(ocupado), 0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(16'd0, 20'h00000);
        wait_idle();
        issue(16'd225, 20'h00225);
        wait_idle();
        issue(16'd65025, 20'h65025);
        wait_idle();
        issue(16'hFFFF, 20'h65535);
        wait_idle();

        // start during a conversion must be ignored
        p0 = pronto_cnt;
        issue(16'd1234, 20'h01234);
        repeat (4) @(negedge clock);
        start = 1'b1;
        valor = 16'd9999;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clock);
        check("ignored_start_count", pronto_cnt - p0, 1);

        // reset mid-conversion aborts without pronto
        issue(16'd4321, 20'h04321);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        @(negedge clock);
        check("abort_bcd", int'(bcd), 0);
        check("abort_pronto", int'(pronto), 0);
        check("abort_ocupado", int'(ocupado), 0);
        reset_n = 1'b1;
        p0 = pronto_cnt;
        repeat (25) @(negedge clock);
        check("abort_no_pronto", pronto_cnt - p0, 0);
        issue(16'd42, 20'h00042);
        wait_idle();

        // back-to-back: second start in the pronto cycle
        issue(16'd7, 20'h00007);
        n = 0;
        while (!pronto && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b2b_pronto_seen", int'(pronto), 1);
        issue(16'd100, 20'h00100);
        wait_idle();

        // random regression
        for (int i = 0; i < 1000; i++) begin
            v = L'($urandom_range(0, 65535));
            issue(v, golden(int'(v)));
            wait_idle();
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
